score_text_renderer: RTL and testbench

//  Pixel-level renderer for an NCHARS-digit score field (4x5-cell block font) on the VGA path.

---
 rtl/score_text_renderer_if.sv | 30 +++
 rtl/score_text_renderer.sv | 155 +++++++++++++++
 tb/tb_score_text_renderer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/score_text_renderer_if.sv
// Pixel/control bundle between the video timing path and the score text renderer.
// master = the driving side (timing generator / game logic), slave = the renderer.
interface score_text_renderer_if #(
  parameter int NCHARS = 4
);
  localparam int IDXW = (NCHARS > 1) ? $clog2(NCHARS) : 1;

  logic [9:0]      x;
  logic [9:0]      y;
  logic [9:0]      x0;
  logic [9:0]      y0;
  logic            en;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [3:0]      wr_code;
  logic            lz_blank;
  logic            blink_en;
  logic            frame_tick;
  logic            disp;

  modport master (
    output x, y, x0, y0, en, wr_en, wr_idx, wr_code, lz_blank, blink_en, frame_tick,
    input  disp
  );

  modport slave (
    input  x, y, x0, y0, en, wr_en, wr_idx, wr_code, lz_blank, blink_en, frame_tick,
    output disp
  );
endinterface

// File: rtl/score_text_renderer.sv
// Score field renderer: NCHARS digits in a 4x5-cell block font, scalable cells,
// leading-zero blanking and frame-synchronous blinking. Two-stage pixel pipeline.
module score_text_renderer #(
  parameter int NCHARS       = 4,
  parameter int CELL_LOG2    = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  score_text_renderer_if.slave  bus
);
  localparam int IDXW    = (NCHARS > 1) ? $clog2(NCHARS) : 1;
  localparam int NBUF    = 1 << IDXW;
  localparam int CELL    = 1 << CELL_LOG2;
  localparam int FIELD_W = NCHARS * 5 * CELL;
  localparam int FIELD_H = 5 * CELL;
  localparam int CNTW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Glyph row lookup; one nibble per row, MSB is the leftmost column.
  function automatic logic [3:0] font_row(input logic [3:0] code, input logic [2:0] row);
    logic [19:0] g;
    case (code)
      4'd0:    g = 20'hF999F;
      4'd1:    g = 20'h11111;
      4'd2:    g = 20'hF1F8F;
      4'd3:    g = 20'hF1F1F;
      4'd4:    g = 20'h99F11;
      4'd5:    g = 20'hF8F1F;
      4'd6:    g = 20'hF8F9F;
      4'd7:    g = 20'hF1111;
      4'd8:    g = 20'hF9F9F;
      4'd9:    g = 20'hF9F1F;
      default: g = 20'h00000;
    endcase
    case (row)
      3'd0:    font_row = g[19:16];
      3'd1:    font_row = g[15:12];
      3'd2:    font_row = g[11:8];
      3'd3:    font_row = g[7:4];
      3'd4:    font_row = g[3:0];
      default: font_row = 4'h0;
    endcase
  endfunction

  logic [10:0]     dx_s, dy_s, ccol_s;
  logic            inside_s;
  logic [IDXW-1:0] char_s;
  logic [2:0]      col_s, row_s;

  logic            valid_r;
  logic [IDXW-1:0] char_r;
  logic [2:0]      col_r, row_r;

  logic [3:0]      buf_r [NBUF];
  logic [CNTW-1:0] count_r;
  logic            phase_r;
  logic            disp_r;

  logic [3:0]      code_s, glyph_s;
  logic            pix_s, run_s, disp_next_s;
  logic [NBUF-1:0] lz_sup_s;

  // Field geometry: 11-bit offsets so the comparisons never wrap.
  always_comb begin
    dx_s     = {1'b0, bus.x} - {1'b0, bus.x0};
    dy_s     = {1'b0, bus.y} - {1'b0, bus.y0};
    inside_s = (bus.x >= bus.x0) && (dx_s < 11'(FIELD_W)) &&
               (bus.y >= bus.y0) && (dy_s < 11'(FIELD_H));
    ccol_s   = dx_s >> CELL_LOG2;
    char_s   = IDXW'(ccol_s / 11'd5);
    col_s    = 3'(ccol_s % 11'd5);
    row_s    = 3'(dy_s >> CELL_LOG2);
  end

  // Stage 1: register hit and cell coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      char_r  <= '0;
      col_r   <= 3'd0;
      row_r   <= 3'd0;
    end else begin
      valid_r <= inside_s && bus.en;
      char_r  <= char_s;
      col_r   <= col_s;
      row_r   <= row_s;
    end
  end

  // Digit buffer; out-of-range indices are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBUF; i++) buf_r[i] <= 4'hF;
    end else if (bus.wr_en && (32'(bus.wr_idx) < NCHARS)) begin
      buf_r[bus.wr_idx] <= bus.wr_code;
    end else begin
      for (int i = 0; i < NBUF; i++) buf_r[i] <= buf_r[i];
    end
  end

  // Blink timer: counts frame ticks, toggles phase every BLINK_FRAMES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      phase_r <= 1'b0;
    end else if (!bus.blink_en) begin
      count_r <= '0;
      phase_r <= 1'b0;
    end else if (bus.frame_tick) begin
      if (count_r == CNTW'(BLINK_FRAMES - 1)) begin
        count_r <= '0;
        phase_r <= ~phase_r;
      end else begin
        count_r <= count_r + 1'b1;
        phase_r <= phase_r;
      end
    end else begin
      count_r <= count_r;
      phase_r <= phase_r;
    end
  end

  // Leading-zero suppression mask from the live buffer; last digit always shown.
  always_comb begin
    run_s    = 1'b1;
    lz_sup_s = '0;
    for (int i = 0; i < NCHARS; i++) begin
      run_s       = run_s && ((buf_r[i] == 4'd0) || (buf_r[i] >= 4'd10));
      lz_sup_s[i] = bus.lz_blank && run_s && (i != NCHARS - 1);
    end
  end

  // Stage 2 decision: glyph bit, gap column, suppression and blink.
  always_comb begin
    code_s  = buf_r[char_r];
    glyph_s = font_row(code_s, row_r);
    if (col_r < 3'd4) begin
      pix_s = glyph_s[2'd3 - col_r[1:0]];
    end else begin
      pix_s = 1'b0;
    end
    disp_next_s = valid_r && pix_s && !lz_sup_s[char_r] && !(bus.blink_en && phase_r);
  end

  // Stage 2: registered pixel output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_r <= 1'b0;
    end else begin
      disp_r <= disp_next_s;
    end
  end

  assign bus.disp = disp_r;
endmodule

// File: tb/tb_score_text_renderer.sv
// Directed bench for score_text_renderer: geometry, font, buffer, blanking, blink, reset.
module tb_score_text_renderer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  score_text_renderer_if #(.NCHARS(4)) bus1 ();
  score_text_renderer_if #(.NCHARS(3)) bus2 ();

  score_text_renderer #(.NCHARS(4), .CELL_LOG2(3), .BLINK_FRAMES(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  score_text_renderer #(.NCHARS(3), .CELL_LOG2(3), .BLINK_FRAMES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic pix1(input logic [9:0] px, input logic [9:0] py);
    bus1.x = px;
    bus1.y = py;
    step();
    step();
  endtask

  task automatic wr1(input logic [1:0] idx, input logic [3:0] code);
    bus1.wr_en = 1'b1; bus1.wr_idx = idx; bus1.wr_code = code;
    step();
    bus1.wr_en = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] idx, input logic [3:0] code);
    bus2.wr_en = 1'b1; bus2.wr_idx = idx; bus2.wr_code = code;
    step();
    bus2.wr_en = 1'b0;
  endtask

  task automatic tick1();
    bus1.frame_tick = 1'b1;
    step();
    bus1.frame_tick = 1'b0;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus1.x = 10'd0; bus1.y = 10'd0; bus1.x0 = 10'd100; bus1.y0 = 10'd50;
    bus1.en = 1'b0; bus1.wr_en = 1'b0; bus1.wr_idx = 2'd0; bus1.wr_code = 4'd0;
    bus1.lz_blank = 1'b0; bus1.blink_en = 1'b0; bus1.frame_tick = 1'b0;
    bus2.x = 10'd102; bus2.y = 10'd52; bus2.x0 = 10'd100; bus2.y0 = 10'd50;
    bus2.en = 1'b1; bus2.wr_en = 1'b0; bus2.wr_idx = 2'd0; bus2.wr_code = 4'd0;
    bus2.lz_blank = 1'b0; bus2.blink_en = 1'b0; bus2.frame_tick = 1'b0;
    step();
    step();
    chk("reset_disp1", bus1.disp, 1'b0);
    chk("reset_disp2", bus2.disp, 1'b0);
    rst = 1'b0;

    // Blank buffer after reset shows nothing
    bus1.en = 1'b1;
    pix1(10'd102, 10'd52);
    chk("post_reset_blank", bus1.disp, 1'b0);

    // T1: digit 5 at idx0
    wr1(2'd0, 4'd5);
    pix1(10'd102, 10'd52); chk("t1_5_r0c0", bus1.disp, 1'b1);
    pix1(10'd110, 10'd60); chk("t1_5_r1c1", bus1.disp, 1'b0);
    pix1(10'd102, 10'd60); chk("t1_5_r1c0", bus1.disp, 1'b1);
    bus1.en = 1'b0;
    pix1(10'd102, 10'd52); chk("t1_en_low", bus1.disp, 1'b0);
    bus1.en = 1'b1;

    // T2: gap column, next char, edges
    wr1(2'd1, 4'd1);
    wr1(2'd3, 4'd8);
    pix1(10'd135, 10'd52); chk("t2_gap_135", bus1.disp, 1'b0);
    pix1(10'd164, 10'd52); chk("t2_1_c3", bus1.disp, 1'b1);
    pix1(10'd140, 10'd52); chk("t2_1_c0", bus1.disp, 1'b0);
    pix1(10'd139, 10'd52); chk("t2_gap_139", bus1.disp, 1'b0);
    pix1(10'd99,  10'd52); chk("t2_x_left", bus1.disp, 1'b0);
    pix1(10'd251, 10'd52); chk("t2_dx151", bus1.disp, 1'b1);
    pix1(10'd259, 10'd52); chk("t2_dx159", bus1.disp, 1'b0);
    pix1(10'd260, 10'd52); chk("t2_dx160", bus1.disp, 1'b0);
    pix1(10'd100, 10'd89); chk("t2_dy39", bus1.disp, 1'b1);
    pix1(10'd100, 10'd90); chk("t2_dy40", bus1.disp, 1'b0);

    // T3: leading-zero blanking with buf={0,0,7,0}
    wr1(2'd0, 4'd0); wr1(2'd1, 4'd0); wr1(2'd2, 4'd7); wr1(2'd3, 4'd0);
    bus1.lz_blank = 1'b1;
    pix1(10'd100, 10'd52); chk("t3_lz_idx0", bus1.disp, 1'b0);
    pix1(10'd140, 10'd52); chk("t3_lz_idx1", bus1.disp, 1'b0);
    pix1(10'd180, 10'd52); chk("t3_lz_idx2", bus1.disp, 1'b1);
    pix1(10'd220, 10'd52); chk("t3_lz_idx3", bus1.disp, 1'b1);
    wr1(2'd2, 4'd0);
    pix1(10'd180, 10'd52); chk("t3_allz_idx2", bus1.disp, 1'b0);
    pix1(10'd220, 10'd52); chk("t3_allz_idx3", bus1.disp, 1'b1);
    bus1.lz_blank = 1'b0;
    pix1(10'd100, 10'd52); chk("t3_nolz_idx0", bus1.disp, 1'b1);

    // T4: blink with BLINK_FRAMES=2 on a lit pixel
    bus1.blink_en = 1'b1;
    pix1(10'd102, 10'd52); chk("t4_start", bus1.disp, 1'b1);
    tick1(); chk("t4_tick1", bus1.disp, 1'b1);
    tick1(); chk("t4_tick2", bus1.disp, 1'b0);
    tick1(); chk("t4_tick3", bus1.disp, 1'b0);
    tick1(); chk("t4_tick4", bus1.disp, 1'b1);
    tick1(); chk("t4_tick5", bus1.disp, 1'b1);
    // Tick and write together: idx1 <- 8
    bus1.frame_tick = 1'b1;
    bus1.wr_en = 1'b1; bus1.wr_idx = 2'd1; bus1.wr_code = 4'd8;
    step();
    bus1.frame_tick = 1'b0; bus1.wr_en = 1'b0;
    step();
    chk("t4_tick6", bus1.disp, 1'b0);
    bus1.blink_en = 1'b0;
    step();
    chk("t4_unblink", bus1.disp, 1'b1);
    pix1(10'd148, 10'd66); chk("t4_wr_with_tick", bus1.disp, 1'b1);

    // T5: read-during-write sees the old glyph (0 -> 8 at row2 col1 of idx2)
    bus1.x = 10'd188; bus1.y = 10'd66;
    step();
    bus1.wr_en = 1'b1; bus1.wr_idx = 2'd2; bus1.wr_code = 4'd8;
    step();
    bus1.wr_en = 1'b0;
    chk("t5_old_glyph", bus1.disp, 1'b0);
    step();
    chk("t5_new_glyph", bus1.disp, 1'b1);

    // Out-of-range write on a 3-digit field is dropped
    wr2(2'd3, 4'd8);
    step(); step();
    chk("t5_idx_oob", bus2.disp, 1'b0);
    wr2(2'd0, 4'd8);
    step(); step();
    chk("t5_idx0_wr", bus2.disp, 1'b1);

    // T6: reset mid-line with blink phase set
    bus1.blink_en = 1'b1;
    tick1(); tick1();
    chk("t6_pre_phase", bus1.disp, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_immediate", bus2.disp, 1'b0);
    step();
    chk("t6_rst_held", bus1.disp, 1'b0);
    rst = 1'b0;
    step(); step();
    chk("t6_blank_buf1", bus1.disp, 1'b0);
    chk("t6_blank_buf2", bus2.disp, 1'b0);
    wr1(2'd2, 4'd8);
    step(); step();
    chk("t6_phase0", bus1.disp, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
